// File: rtl/scene_renderer.sv
// VGA raster generator and 2-stage sprite renderer for the game state.
// Game inputs are snapshotted once per frame, after the last active line, so a frame never tears.
module scene_renderer #(
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned H_FP         = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BP         = 48,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_FP         = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BP         = 33,
    parameter int unsigned NUM_METEORS  = 6,
    parameter int unsigned SHIP_SZ      = 16,
    parameter int unsigned METEOR_SZ    = 16,
    parameter int unsigned FLASH_FRAMES = 30
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pix_en,
    input  logic [9:0]             ship_x,
    input  logic [8:0]             ship_y,
    input  logic [9:0]             meteor_x [NUM_METEORS],
    input  logic [8:0]             meteor_y [NUM_METEORS],
    input  logic [NUM_METEORS-1:0] meteor_active,
    input  logic [2:0]             lives,
    input  logic                   game_over,
    input  logic                   collision,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   blank_n,
    output logic [7:0]             vga_r,
    output logic [7:0]             vga_g,
    output logic [7:0]             vga_b,
    output logic                   frame_tick
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W     = $clog2(H_TOTAL);
    localparam int unsigned V_W     = $clog2(V_TOTAL);
    localparam int unsigned FW_RAW  = $clog2(FLASH_FRAMES + 1);
    // Ship colour tests flash[2], so the counter is never narrower than 3 bits.
    localparam int unsigned FW      = (FW_RAW < 3) ? 3 : FW_RAW;

    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [H_W-1:0] h;
    logic [V_W-1:0] v;
    logic [10:0]    x, y;
    logic           hsync0, vsync0, active0, snap;

    logic [9:0]             sh_ship_x;
    logic [8:0]             sh_ship_y;
    logic [9:0]             sh_met_x [NUM_METEORS];
    logic [8:0]             sh_met_y [NUM_METEORS];
    logic [NUM_METEORS-1:0] sh_met_act;
    logic [2:0]             sh_lives;
    logic                   sh_game_over;

    logic          ship_c, met_c, hud_c;
    logic          act1, hs1, vs1, ship1, met1, hud1;
    logic [23:0]   rgb_c;
    logic [FW-1:0] flash;
    logic          coll_q;

    // Raster counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (pix_en) begin
            if (h == H_W'(H_TOTAL - 1)) begin
                h <= '0;
                v <= (v == V_W'(V_TOTAL - 1)) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

    always_comb begin
        x       = 11'(h);
        y       = 11'(v);
        hsync0  = !(x >= HS_START && x < HS_END);
        vsync0  = !(y >= VS_START && y < VS_END);
        active0 = (x < 11'(H_ACTIVE)) && (y < 11'(V_ACTIVE));
        snap    = pix_en && (h == H_W'(H_TOTAL - 1)) && (v == V_W'(V_ACTIVE - 1));
    end

    // Shadow copy of the game state, taken after the last active line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_ship_x    <= '0;
            sh_ship_y    <= '0;
            sh_met_act   <= '0;
            sh_lives     <= '0;
            sh_game_over <= 1'b0;
            for (int i = 0; i < NUM_METEORS; i++) begin
                sh_met_x[i] <= '0;
                sh_met_y[i] <= '0;
            end
        end else if (snap) begin
            sh_ship_x    <= ship_x;
            sh_ship_y    <= ship_y;
            sh_met_act   <= meteor_active;
            sh_lives     <= lives;
            sh_game_over <= game_over;
            for (int i = 0; i < NUM_METEORS; i++) begin
                sh_met_x[i] <= meteor_x[i];
                sh_met_y[i] <= meteor_y[i];
            end
        end
    end

    // 11-bit compares so sprite right/bottom edges never wrap past the 10/9-bit range
    always_comb begin
        ship_c = (x >= {1'b0, sh_ship_x}) && (x < {1'b0, sh_ship_x} + 11'(SHIP_SZ)) &&
                 (y >= {2'b0, sh_ship_y}) && (y < {2'b0, sh_ship_y} + 11'(SHIP_SZ));
        met_c = 1'b0;
        for (int i = 0; i < NUM_METEORS; i++) begin
            if (sh_met_act[i] &&
                (x >= {1'b0, sh_met_x[i]}) && (x < {1'b0, sh_met_x[i]} + 11'(METEOR_SZ)) &&
                (y >= {2'b0, sh_met_y[i]}) && (y < {2'b0, sh_met_y[i]} + 11'(METEOR_SZ))) begin
                met_c = 1'b1;
            end
        end
        hud_c = 1'b0;
        if (y >= 11'd8 && y < 11'd16) begin
            for (int i = 0; i < 7; i++) begin
                if ((3'(i) < sh_lives) && (x >= 11'(8 + 12 * i)) && (x < 11'(16 + 12 * i))) begin
                    hud_c = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act1  <= 1'b0;
            hs1   <= 1'b1;
            vs1   <= 1'b1;
            ship1 <= 1'b0;
            met1  <= 1'b0;
            hud1  <= 1'b0;
        end else if (pix_en) begin
            act1  <= active0;
            hs1   <= hsync0;
            vs1   <= vsync0;
            ship1 <= ship_c;
            met1  <= met_c;
            hud1  <= hud_c;
        end
    end

    always_comb begin
        if (!act1) begin
            rgb_c = 24'h000000;
        end else if (hud1) begin
            rgb_c = 24'hFFFF00;
        end else if (ship1 && !sh_game_over) begin
            rgb_c = (flash != '0 && flash[2]) ? 24'hFFFFFF : 24'h00FF00;
        end else if (met1) begin
            rgb_c = 24'h808080;
        end else begin
            rgb_c = sh_game_over ? 24'h400000 : 24'h000020;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blank_n <= 1'b0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            vga_r   <= '0;
            vga_g   <= '0;
            vga_b   <= '0;
        end else if (pix_en) begin
            blank_n <= act1;
            hsync   <= hs1;
            vsync   <= vs1;
            {vga_r, vga_g, vga_b} <= rgb_c;
        end
    end

    // Runs on every clk: the collision edge must not be missed while pix_en is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_tick <= 1'b0;
            coll_q     <= 1'b0;
            flash      <= '0;
        end else begin
            frame_tick <= snap;
            coll_q     <= collision;
            if (collision && !coll_q) begin
                flash <= FW'(FLASH_FRAMES);
            end else if (frame_tick && flash != '0) begin
                flash <= flash - 1'b1;
            end
        end
    end

endmodule
